// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, small in-order fetch buffer, redirect and fault halting.
// Optional performance counters enabled by defining FETCH_PERF_CNT_EN.
//
// state  | meaning
// S_RUN  | fetching one word per cycle while the buffer has room
// S_HALT | an exception entry was pushed; no fetch until redirect or reset
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] pc_addr,
  input  logic [31:0] instruction,
  input  logic        imem_exc_en,
  input  logic [3:0]  imem_exc_code,
  input  logic [63:0] imem_exc_val,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  output logic        if_exc_en,
  output logic [3:0]  if_exc_code,
  output logic [63:0] if_exc_val
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_stall_cnt
`endif
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t        state, state_nxt;
  logic [63:0]   pc, pc_nxt;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          pop, push, misalign, fault;

  logic [31:0]   wr_instr;
  logic [3:0]    wr_code;
  logic [63:0]   wr_val;

  logic [63:0]   buf_pc       [DEPTH];
  logic [31:0]   buf_instr    [DEPTH];
  logic          buf_exc_en   [DEPTH];
  logic [3:0]    buf_exc_code [DEPTH];
  logic [63:0]   buf_exc_val  [DEPTH];

  assign pc_addr = pc;

  always_comb begin
    pop       = (count != '0) && if_ready && !redirect_en;
    push      = (state == S_RUN) && !redirect_en && ((count < FULL) || pop);
    // A misaligned PC can only come from a redirect; it replaces the memory fetch.
    misalign  = (pc[1:0] != 2'b00);
    fault     = misalign || imem_exc_en;
    state_nxt = state;
    pc_nxt    = pc;
    if (redirect_en) begin
      state_nxt = S_RUN;
      pc_nxt    = redirect_pc;
    end else if (push) begin
      if (fault) state_nxt = S_HALT;
      else       pc_nxt    = pc + 64'd4;
    end
  end

  always_comb begin
    wr_instr = fault ? NOP : instruction;
    wr_code  = 4'd0;
    wr_val   = 64'd0;
    if (misalign) begin
      wr_code = 4'd0;
      wr_val  = pc;
    end else if (imem_exc_en) begin
      wr_code = imem_exc_code;
      wr_val  = imem_exc_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_RUN;
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (redirect_en) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]       <= pc;
      buf_instr[wr_ptr]    <= wr_instr;
      buf_exc_en[wr_ptr]   <= fault;
      buf_exc_code[wr_ptr] <= wr_code;
      buf_exc_val[wr_ptr]  <= wr_val;
    end
  end

  always_comb begin
    if_valid    = 1'b0;
    if_instr    = NOP;
    if_pc       = 64'd0;
    if_exc_en   = 1'b0;
    if_exc_code = 4'd0;
    if_exc_val  = 64'd0;
    if (count != '0) begin
      if_valid    = 1'b1;
      if_instr    = buf_instr[rd_ptr];
      if_pc       = buf_pc[rd_ptr];
      if_exc_en   = buf_exc_en[rd_ptr];
      if_exc_code = buf_exc_code[rd_ptr];
      if_exc_val  = buf_exc_val[rd_ptr];
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 64'd0;
      perf_stall_cnt <= 64'd0;
    end else begin
      if (if_valid && if_ready)  perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if (if_valid && !if_ready) perf_stall_cnt <= perf_stall_cnt + 64'd1;
    end
  end
`else
  // Counters absent in this build.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit (DEPTH=2), plus an asynchronous reset sequence.
module tb_fetch_unit;

  localparam logic [63:0] R   = 64'h0000_0000_8000_0000;
  localparam logic [63:0] F   = 64'h0000_0000_8004_0000;
  localparam logic [63:0] W   = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc_addr;
  logic [31:0] instruction;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        if_exc_en;
  logic [3:0]  if_exc_code;
  logic [63:0] if_exc_val;
`ifdef FETCH_PERF_CNT_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] mw(input logic [63:0] a);
    return a[31:0] ^ 32'h0BAD_F00D;
  endfunction

  assign instruction  = mw(pc_addr);
  assign imem_exc_val = pc_addr;

  fetch_unit dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .instruction(instruction),
    .imem_exc_en(imem_exc_en), .imem_exc_code(imem_exc_code), .imem_exc_val(imem_exc_val),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .if_exc_en(if_exc_en), .if_exc_code(if_exc_code), .if_exc_val(if_exc_val)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  typedef struct {
    logic        rst, rdy, rde;
    logic [63:0] rdpc;
    logic        exen;
    logic [3:0]  excode;
    logic [63:0] e_pc;
    logic        e_v;
    logic [63:0] e_ipc;
    logic [31:0] e_instr;
    logic        e_ex;
    logic [3:0]  e_code;
    logic [63:0] e_val;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;
  int row   = 0;

  function automatic vec_t mk(logic r, logic rdy, logic rde, logic [63:0] rdpc,
                              logic exen, logic [3:0] excode, logic [63:0] epc,
                              logic ev, logic [63:0] eipc, logic eex,
                              logic [3:0] ecode, logic [63:0] evl);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.rde = rde; v.rdpc = rdpc;
    v.exen = exen; v.excode = excode;
    v.e_pc = epc; v.e_v = ev; v.e_ipc = eipc;
    v.e_instr = (ev && !eex) ? mw(eipc) : NOP;
    v.e_ex = eex; v.e_code = ecode; v.e_val = evl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
    end
  endtask

  initial begin
    //             rst rdy rde rdpc          exen code  pc       v ipc      ex code val
    vecs.push_back(mk(1, 1, 0, 64'd0,        0, 4'd0, R,       0, 64'd0,  0, 4'd0, 64'd0));
    vecs.push_back(mk(0, 0, 0, 64'd0,        0, 4'd0, R,       0, 64'd0,  0, 4'd0, 64'd0));
    vecs.push_back(mk(0, 0, 0, 64'd0,        0, 4'd0, R+4,     1, R,      0, 4'd0, 64'd0));
    vecs.push_back(mk(0, 0, 0, 64'd0,        0, 4'd0, R+8,     1, R,      0, 4'd0, 64'd0));
    vecs.push_back(mk(0, 0, 0, 64'd0,        0, 4'd0, R+8,     1, R,      0, 4'd0, 64'd0));
    vecs.push_back(mk(0, 0, 0, 64'd0,        0, 4'd0, R+8,     1, R,      0, 4'd0, 64'd0));
    vecs.push_back(mk(0, 1, 0, 64'd0,        0, 4'd0, R+8,     1, R,      0, 4'd0, 64'd0));
    vecs.push_back(mk(0, 1, 0, 64'd0,        0, 4'd0, R+'hC,   1, R+4,    0, 4'd0, 64'd0));
    vecs.push_back(mk(0, 1, 0, 64'd0,        0, 4'd0, R+'h10,  1, R+8,    0, 4'd0, 64'd0));
    vecs.push_back(mk(0, 0, 1, R+'h100,      0, 4'd0, R+'h14,  1, R+'hC,  0, 4'd0, 64'd0));
    vecs.push_back(mk(0, 1, 0, 64'd0,        0, 4'd0, R+'h100, 0, 64'd0,  0, 4'd0, 64'd0));
    vecs.push_back(mk(0, 1, 0, 64'd0,        0, 4'd0, R+'h104, 1, R+'h100,0, 4'd0, 64'd0));
    vecs.push_back(mk(0, 1, 1, F,            0, 4'd0, R+'h108, 1, R+'h104,0, 4'd0, 64'd0));
    vecs.push_back(mk(0, 1, 0, 64'd0,        1, 4'd1, F,       0, 64'd0,  0, 4'd0, 64'd0));
    vecs.push_back(mk(0, 0, 0, 64'd0,        0, 4'd0, F,       1, F,      1, 4'd1, F));
    vecs.push_back(mk(0, 0, 0, 64'd0,        0, 4'd0, F,       1, F,      1, 4'd1, F));
    vecs.push_back(mk(0, 1, 0, 64'd0,        0, 4'd0, F,       1, F,      1, 4'd1, F));
    vecs.push_back(mk(0, 1, 0, 64'd0,        0, 4'd0, F,       0, 64'd0,  0, 4'd0, 64'd0));
    vecs.push_back(mk(0, 1, 1, R+'h102,      0, 4'd0, F,       0, 64'd0,  0, 4'd0, 64'd0));
    vecs.push_back(mk(0, 0, 0, 64'd0,        0, 4'd0, R+'h102, 0, 64'd0,  0, 4'd0, 64'd0));
    vecs.push_back(mk(0, 0, 0, 64'd0,        0, 4'd0, R+'h102, 1, R+'h102,1, 4'd0, R+'h102));
    vecs.push_back(mk(0, 1, 0, 64'd0,        0, 4'd0, R+'h102, 1, R+'h102,1, 4'd0, R+'h102));
    vecs.push_back(mk(0, 1, 0, 64'd0,        0, 4'd0, R+'h102, 0, 64'd0,  0, 4'd0, 64'd0));
    vecs.push_back(mk(0, 1, 1, R+'h200,      0, 4'd0, R+'h102, 0, 64'd0,  0, 4'd0, 64'd0));
    vecs.push_back(mk(0, 0, 0, 64'd0,        0, 4'd0, R+'h200, 0, 64'd0,  0, 4'd0, 64'd0));
    vecs.push_back(mk(0, 0, 0, 64'd0,        0, 4'd0, R+'h204, 1, R+'h200,0, 4'd0, 64'd0));
    vecs.push_back(mk(0, 1, 1, W,            0, 4'd0, R+'h208, 1, R+'h200,0, 4'd0, 64'd0));
    vecs.push_back(mk(0, 0, 0, 64'd0,        0, 4'd0, W,       0, 64'd0,  0, 4'd0, 64'd0));
    vecs.push_back(mk(0, 0, 0, 64'd0,        0, 4'd0, 64'd0,   1, W,      0, 4'd0, 64'd0));

    rst = 1'b0; if_ready = 1'b0; redirect_en = 1'b0; redirect_pc = 64'd0;
    imem_exc_en = 1'b0; imem_exc_code = 4'd0;
    #2 rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      row           = i;
      rst           = vecs[i].rst;
      if_ready      = vecs[i].rdy;
      redirect_en   = vecs[i].rde;
      redirect_pc   = vecs[i].rdpc;
      imem_exc_en   = vecs[i].exen;
      imem_exc_code = vecs[i].excode;
      #1;
      chk("pc_addr",     pc_addr,             vecs[i].e_pc);
      chk("if_valid",    {63'd0, if_valid},   {63'd0, vecs[i].e_v});
      chk("if_pc",       if_pc,               vecs[i].e_ipc);
      chk("if_instr",    {32'd0, if_instr},   {32'd0, vecs[i].e_instr});
      chk("if_exc_en",   {63'd0, if_exc_en},  {63'd0, vecs[i].e_ex});
      chk("if_exc_code", {60'd0, if_exc_code},{60'd0, vecs[i].e_code});
      chk("if_exc_val",  if_exc_val,          vecs[i].e_val);
`ifdef FETCH_PERF_CNT_EN
      if (i == 6) begin
        chk("perf_stall", perf_stall_cnt, 64'd4);
        chk("perf_fetch", perf_fetch_cnt, 64'd0);
      end
`endif
      @(posedge clk);
      @(negedge clk);
    end

    // Two entries buffered here; reset mid-cycle must clear the head immediately.
    row = 100;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {63'd0, if_valid}, 64'd0);
    chk("async_rst_pc",    pc_addr,           R);
    @(negedge clk);
    rst = 1'b0; if_ready = 1'b1; redirect_en = 1'b0; imem_exc_en = 1'b0;
    #1;
    chk("post_rst_pc",    pc_addr,           R);
    chk("post_rst_valid", {63'd0, if_valid}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("post_rst_ifpc",  if_pc,             R);
    chk("post_rst_valid2",{63'd0, if_valid}, 64'd1);
    chk("post_rst_pc2",   pc_addr,           R + 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
